// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract unit: one BLOCK_BITS-wide carry-lookahead block is resolved per stage,
// and the block carry is registered into the next stage. One operation can be accepted per cycle.
module pipelined_cla_adder #(
  parameter int unsigned NR_BITS    = 16,
  parameter int unsigned BLOCK_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NR_BITS-1:0] a,
  input  logic [NR_BITS-1:0] b,
  input  logic               c_in,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NR_BITS-1:0] sum,
  output logic               c_out,
  output logic               overflow
);

  localparam int unsigned NrBlocks = NR_BITS / BLOCK_BITS;
  localparam int unsigned Last     = NrBlocks - 1;
  localparam int unsigned Msb      = NR_BITS - 1;

  // Full lookahead: each carry is an OR of generate/propagate products, no ripple through c[i].
  function automatic logic [BLOCK_BITS:0] cla_carries(input logic [BLOCK_BITS-1:0] g,
                                                      input logic [BLOCK_BITS-1:0] p,
                                                      input logic              cin);
    logic [BLOCK_BITS:0] c;
    logic                term;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(BLOCK_BITS); i++) begin
      for (int j = 0; j <= i + 1; j++) begin
        term = (j == 0) ? cin : g[j-1];
        for (int m = j; m <= i; m++) begin
          term = term & p[m];
        end
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic                              advance;
  logic                              accept;
  logic [NR_BITS-1:0]                b_eff;
  logic                              cin_eff;

  logic [NrBlocks-1:0]               valid_q;
  logic [NrBlocks-1:0]               c_q;
  logic [NrBlocks-1:0][NR_BITS-1:0]  a_q;
  logic [NrBlocks-1:0][NR_BITS-1:0]  b_q;
  logic [NrBlocks-1:0][NR_BITS-1:0]  s_q;

  // Per-stage results: partial sum with this stage's slice filled in, and carry into next block.
  logic [NrBlocks-1:0][NR_BITS-1:0]  s_fwd;
  logic [NrBlocks-1:0]               blk_cout;

  assign advance = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept  = in_valid && advance;
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = c_in ^ sub;

  for (genvar k = 0; k < NrBlocks; k++) begin : g_blk
    logic [BLOCK_BITS-1:0] gen;
    logic [BLOCK_BITS-1:0] prop;
    logic [BLOCK_BITS:0]   carry;

    assign gen   = a_q[k][k*BLOCK_BITS +: BLOCK_BITS] & b_q[k][k*BLOCK_BITS +: BLOCK_BITS];
    assign prop  = a_q[k][k*BLOCK_BITS +: BLOCK_BITS] ^ b_q[k][k*BLOCK_BITS +: BLOCK_BITS];
    assign carry = cla_carries(gen, prop, c_q[k]);
    assign blk_cout[k] = carry[BLOCK_BITS];

    always_comb begin
      s_fwd[k] = s_q[k];
      s_fwd[k][k*BLOCK_BITS +: BLOCK_BITS] = prop ^ carry[BLOCK_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
    end else if (advance) begin
      valid_q[0] <= accept;
      if (accept) begin
        a_q[0] <= a;
        b_q[0] <= b_eff;
        c_q[0] <= cin_eff;
        s_q[0] <= '0;
      end
      for (int k = 1; k < int'(NrBlocks); k++) begin
        valid_q[k] <= valid_q[k-1];
        a_q[k]     <= a_q[k-1];
        b_q[k]     <= b_q[k-1];
        c_q[k]     <= blk_cout[k-1];
        s_q[k]     <= s_fwd[k-1];
      end
    end
  end

  // The last block is resolved combinationally from the final stage register.
  assign out_valid = valid_q[Last];
  assign sum       = s_fwd[Last];
  assign c_out     = blk_cout[Last];
  assign overflow  = (a_q[Last][Msb] == b_q[Last][Msb]) && (sum[Msb] != a_q[Last][Msb]);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: arithmetic reference model with an in-order
// expectation queue, plus directed vectors with literal expected results and latency.
module tb_pipelined_cla_adder;

  localparam int unsigned W  = 16;
  localparam int unsigned BB = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_co;
  logic         prev_ov;

  pipelined_cla_adder #(
    .NR_BITS   (W),
    .BLOCK_BITS(BB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/carry, signed range for overflow.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tc, input logic ts);
    exp_t        e;
    int          sa;
    int          sb;
    int          r;
    logic [16:0] u;
    sa = int'($signed(ta));
    sb = int'($signed(tb_));
    if (!ts) begin
      u    = {1'b0, ta} + {1'b0, tb_} + 17'(tc);
      e.s  = u[15:0];
      e.co = u[16];
      r    = sa + sb + int'(tc);
    end else begin
      e.s  = ta - tb_ - 16'(tc);
      e.co = ({1'b0, ta} >= ({1'b0, tb_} + 17'(tc)));
      r    = sa - sb - int'(tc);
    end
    e.ov = (r > 32767) || (r < -32768);
    return e;
  endfunction

  // Compare process: checks outputs every cycle, then records any accept about to happen.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'({sum, c_out, overflow}), 32'd0);
    end else begin
      chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("hold", 32'({out_valid, sum, c_out, overflow}), 32'({1'b1, prev_sum, prev_co, prev_ov}));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          chk("result", 32'({sum, c_out, overflow}), 32'({e.s, e.co, e.ov}));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_co    = c_out;
      prev_ov    = overflow;
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tc, input logic ts);
    int n;
    a = ta;
    b = tb_;
    c_in = tc;
    sub = ts;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts, input logic [W-1:0] es,
                          input logic eco, input logic eov);
    int lat;
    send(ta, tb_, tc, ts);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd3);
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_c_out"}, 32'(c_out), 32'(eco));
    chk({name, "_overflow"}, 32'(overflow), 32'(eov));
    step();
  endtask

  task automatic stall_once();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("stall_wait_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    repeat (5) begin
      step();
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_sum", 32'(sum), 32'd0);

    directed("full_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("borrow_in", 16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFE, 1'b1, 1'b0);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Reset with three operations in flight: none may emerge.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b1, 1'b0);
    send(16'h5555, 16'h0001, 1'b0, 1'b1);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();

    // Back-to-back stream.
    for (int i = 0; i < 20; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (6) step();

    // Backpressure on a continuous stream, then on a stream with gaps.
    fork
      for (int i = 0; i < 12; i++) begin
        send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      stall_once();
    join
    repeat (6) step();
    fork
      for (int i = 0; i < 12; i++) begin
        send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        repeat ($urandom_range(0, 2)) step();
      end
      stall_once();
    join
    repeat (8) step();

    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
